addsub_seq_ctrl: RTL

- Multi-precision add/subtract sequencer that time-shares one external 4-bit ripple adder (ports a, b, ci, s, co).
- Latches WIDTH-bit operands on a start handshake.
- Feeds the adder one nibble per cycle, LSB first, chaining the carry through a register.
- Assembles the result, carry and signed overflow, then pulses done.

---
 rtl/addsub_seq_ctrl_if.sv | 24 ++
 rtl/addsub_seq_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/addsub_seq_ctrl_if.sv
// Request/response bundle for addsub_seq_ctrl: operands and opcode in, result, flags and status out.
interface addsub_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, sub, op_a, op_b,
    input  result, carry_out, overflow, busy, done
  );

  modport slave (
    input  start, sub, op_a, op_b,
    output result, carry_out, overflow, busy, done
  );
endinterface

// File: rtl/addsub_seq_ctrl.sv
// Multi-precision add/subtract sequencer sharing one external 4-bit adder, one nibble per cycle, LSB first.
// Optional signed saturation of an overflowed result is enabled by defining ADDSUB_SEQ_SAT_EN.
//
// state | meaning
// IDLE  | waiting for start; adder inputs held at 0
// RUN   | one nibble per edge through the shared adder, carry chained in cy_q
// DONE  | single cycle with done=1, busy=1; returns to IDLE unconditionally
module addsub_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  addsub_seq_ctrl_if.slave     bus,
  output logic [3:0]           fa_a,
  output logic [3:0]           fa_b,
  output logic                 fa_ci,
  input  logic [3:0]           fa_s,
  input  logic                 fa_co
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  logic [CW-1:0]    k;
  logic             cy_q;

  logic [CW+1:0]    base;
  logic             last;
  logic             ovf_raw;

  assign base = {k, 2'b00};
  assign last = (k == K_LAST);
  // Sign of the last sum nibble is the result sign; overflow iff operands agree in sign and the result does not.
  assign ovf_raw = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sub_q)) && (fa_s[3] != a_q[WIDTH-1]);

  always_comb begin
    fa_a  = 4'd0;
    fa_b  = 4'd0;
    fa_ci = 1'b0;
    if (state == RUN) begin
      fa_a  = a_q[base +: 4];
      fa_b  = b_q[base +: 4] ^ {4{sub_q}};
      fa_ci = (k == '0) ? sub_q : cy_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      sub_q         <= 1'b0;
      k             <= '0;
      cy_q          <= 1'b0;
      bus.result    <= '0;
      bus.carry_out <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q           <= bus.op_a;
            b_q           <= bus.op_b;
            sub_q         <= bus.sub;
            k             <= '0;
            cy_q          <= 1'b0;
            bus.result    <= '0;
            bus.carry_out <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.busy      <= 1'b1;
            state         <= RUN;
          end
        end
        RUN: begin
          bus.result[base +: 4] <= fa_s;
          cy_q                  <= fa_co;
          k                     <= k + 1'b1;
          if (last) begin
            bus.carry_out <= fa_co;
            bus.overflow  <= ovf_raw;
            bus.done      <= 1'b1;
            state         <= DONE;
`ifdef ADDSUB_SEQ_SAT_EN
            if (ovf_raw) begin
              bus.result <= a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
            end
`else
`endif
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule
